freq_counter_bcd: RTL and testbench
===================================

// Module: freq_counter_bcd
// PURPOSE
//  Parametrised multi-digit frequency counter: counts rising edges of an async input over a
//  programmable gate window, latches the result as BCD and drives a time-multiplexed 7-seg display.
//  Successor to the 2-digit counter: generic digit count, gate width, overflow flag, result-valid strobe.
//  Sits between the top-level pad wrapper (ui_in/uio_in) and the display outputs.
// PARAMETERS
//  DIGITS       4        number of BCD display digits (1..8)
//  PERIOD_W     16       width of gate-period register (clk cycles per gate window)
//  RESET_PERIOD 16'd1000 gate period loaded at reset
//  SYNC_STAGES  2        flops in signal input synchroniser (>=2)
//  MUX_DIV      1024     clk cycles each digit is shown before advancing
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-high reset
//  signal       in   1         async input to measure
//  period       in   PERIOD_W  new gate period, sampled when period_load=1
//  period_load  in   1         level; period captured every cycle it is high
//  segments     out  7         active-high segments {g,f,e,d,c,b,a} of selected digit
//  digit_en     out  DIGITS    one-hot digit enable, bit0 = least significant digit
//  overflow     out  1         last latched result exceeded 10^DIGITS-1
//  result_valid out  1         1-cycle pulse when a new result is latched
//  dbg_state    out  2         current FSM state encoding
// BEHAVIOUR
//  Reset: period_reg=RESET_PERIOD, counters/result=0, FSM=CLEAR, digit_en=1, segments=pattern '0',
//   overflow=0, result_valid=0, dbg_state=CLEAR. Reset mid-window discards the partial count.
//  Input: signal through SYNC_STAGES flops, then 1-flop edge detect; edge pulse = sync & ~sync_d.
//   Edge-to-count latency SYNC_STAGES+1 cycles; pulses shorter than 1 clk may be missed.
//  period_reg: loaded from period while period_load=1; used only at next CLEAR (never mid-window).
//   period_reg==0 treated as 1.
//  FSM (dbg_state): CLEAR=0, COUNT=1, LATCH=2.
//   CLEAR: zero BCD counter, gate_cnt <= max(period_reg,1)-1, -> COUNT next cycle.
//   COUNT: each edge pulse increments BCD counter (ripple carry per digit, 9->0 carries).
//    gate_cnt decrements each cycle; when gate_cnt==0 (that cycle's edge still counted) -> LATCH.
//   LATCH: result <= BCD counter, overflow <= ovf_flag, result_valid=1 for this cycle, -> CLEAR.
//   Window = period_reg COUNT cycles; dead time 2 cycles (LATCH+CLEAR); edges there are dropped.
//  Overflow: increment at all-9s sets sticky ovf_flag and holds counter at all-9s (saturate);
//   ovf_flag cleared in CLEAR. Displayed result stays all-9s with overflow=1.
//  Display: free-running MUX_DIV prescaler; on wrap digit_en rotates left one-hot, DIGITS-1 -> 0.
//   segments = decode(result digit selected by digit_en), registered; same-cycle as digit_en.
//   Result update changes segments at next cycle, no glitch on digit_en.
//  Decode: 0-9 standard patterns; codes 10-15 unreachable, decode to all-off.
// STRUCTURE
//  Shared package freq_pkg: FSM state enum (CLEAR/COUNT/LATCH), 7-seg pattern constants SEG_0..SEG_9,
//   SEG_OFF. Sub-module seg7_decode (4-bit BCD in, 7-bit segments out, combinational).
//  BCD counter as generate loop over DIGITS; no binary-to-BCD conversion.
// TESTING
//  1: reset, period=100 loaded, 1 MHz-equiv input (edge every 10 clk) -> result 0010, overflow=0,
//     result_valid pulses every 102 cycles.
//  2: DIGITS=2, period=1000, edge every 4 clk -> counter saturates: result 99, overflow=1;
//     next window with no input -> result 00, overflow=0.
//  3: period_load 50 during mid-COUNT of 1000-cycle window -> current window still 1000 cycles,
//     following window 50 cycles.
//  4: edge timed to reach counter on final COUNT cycle -> counted; edge in LATCH/CLEAR -> dropped.
//  5: period=0 loaded -> window of 1 cycle, FSM cycles every 3 clks, no hang.
//  6: assert reset mid-COUNT with count 0037 -> all outputs at reset values immediately (async);
//     after release first result reflects only post-reset edges; digit_en walks 0001->0010->0100->1000->0001
//     every MUX_DIV clks with matching segments.

Source files
------------

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared FSM states and 7-segment patterns for freq_counter_bcd
package freq_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to 7-segment pattern
module seg7_decode
  import freq_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/freq_counter_bcd.sv
// rtl/freq_counter_bcd.sv - gated BCD frequency counter with multiplexed 7-segment output
module freq_counter_bcd
  import freq_pkg::*;
#(
  parameter int                    DIGITS       = 4,
  parameter int                    PERIOD_W     = 16,
  parameter logic [PERIOD_W-1:0]   RESET_PERIOD = PERIOD_W'(1000),
  parameter int                    SYNC_STAGES  = 2,
  parameter int                    MUX_DIV      = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                signal_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                period_load_i,
  output logic [6:0]          segments_o,
  output logic [DIGITS-1:0]   digit_en_o,
  output logic                overflow_o,
  output logic                result_valid_o,
  output logic [1:0]          dbg_state_o
);

  localparam int MUX_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_d_q;
  logic                    edge_pulse;
  logic [PERIOD_W-1:0]     period_q;
  logic [PERIOD_W-1:0]     gate_q;
  logic [PERIOD_W-1:0]     gate_start;
  state_e                  state_q;
  logic [DIGITS-1:0][3:0]  bcd_q;
  logic [DIGITS-1:0][3:0]  bcd_inc;
  logic [DIGITS-1:0][3:0]  result_q;
  logic [DIGITS:0]         carry;
  logic                    ovf_flag_q;
  logic                    overflow_q;
  logic                    result_valid_q;
  logic [MUX_W-1:0]        mux_cnt_q;
  logic                    mux_wrap;
  logic [DIGITS-1:0]       digit_en_q;
  logic [DIGITS-1:0]       digit_en_d;
  logic [3:0]              digit_sel;
  logic [6:0]              seg_d;
  logic [6:0]              segments_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], signal_i};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_d_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            period_q <= RESET_PERIOD;
    else if (period_load_i) period_q <= period_i;
  end

  // A zero period still yields a one-cycle window
  assign gate_start = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  // carry[DIGITS] doubles as the all-nines detect for saturation
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign bcd_inc[i]   = carry[i] ? ((bcd_q[i] == 4'd9) ? 4'd0 : bcd_q[i] + 4'd1) : bcd_q[i];
    assign carry[i+1]   = carry[i] & (bcd_q[i] == 4'd9);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= CLEAR;
      gate_q         <= '0;
      bcd_q          <= '0;
      ovf_flag_q     <= 1'b0;
      result_q       <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          bcd_q      <= '0;
          ovf_flag_q <= 1'b0;
          gate_q     <= gate_start;
          state_q    <= COUNT;
        end
        COUNT: begin
          if (edge_pulse) begin
            if (carry[DIGITS]) ovf_flag_q <= 1'b1;
            else               bcd_q      <= bcd_inc;
          end
          gate_q <= gate_q - PERIOD_W'(1);
          if (gate_q == '0) state_q <= LATCH;
        end
        LATCH: begin
          result_q       <= bcd_q;
          overflow_q     <= ovf_flag_q;
          result_valid_q <= 1'b1;
          state_q        <= CLEAR;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign mux_wrap   = (mux_cnt_q == MUX_W'(MUX_DIV - 1));
  assign digit_en_d = mux_wrap ? ((digit_en_q << 1) | (digit_en_q >> (DIGITS - 1))) : digit_en_q;

  // Decode against the next enable so segments and digit_en change together
  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_en_d[i]) digit_sel = digit_sel | result_q[i];
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i (digit_sel),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mux_cnt_q  <= '0;
      digit_en_q <= DIGITS'(1);
      segments_q <= SEG_0;
    end else begin
      mux_cnt_q  <= mux_wrap ? '0 : mux_cnt_q + MUX_W'(1);
      digit_en_q <= digit_en_d;
      segments_q <= seg_d;
    end
  end

  assign segments_o     = segments_q;
  assign digit_en_o     = digit_en_q;
  assign overflow_o     = overflow_q;
  assign result_valid_o = result_valid_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_freq_counter_bcd.sv
// tb/tb_freq_counter_bcd.sv - table-driven scoreboard bench for freq_counter_bcd
module tb_freq_counter_bcd;

  localparam int MUX = 4;
  localparam int LIM = 2200;
  localparam int NV  = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        signal;
  logic [15:0] period = 16'd0;
  logic        period_load = 1'b0;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  den_a;
  logic [1:0]  den_b;
  logic        ovf_a, ovf_b, rv_a, rv_b;
  logic [1:0]  st_a, st_b;

  int   spacing = 0;
  int   ph = 0;
  logic gen_sig = 1'b0;
  logic man_sig = 1'b0;
  logic gen_en = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct { int per; int spc; int cnt; } vec_t;
  typedef struct { int va; int vb; int oa; int ob; int gap; } exp_t;
  vec_t vecs[NV];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Periodic input: one rising edge every `spacing` cycles, idle when 0
  always @(posedge clk) begin
    #1;
    if (spacing == 0) begin
      gen_sig = 1'b0;
      ph = 0;
    end else begin
      gen_sig = (ph < spacing / 2);
      ph = (ph + 1 >= spacing) ? 0 : ph + 1;
    end
  end
  assign signal = gen_en ? gen_sig : man_sig;

  freq_counter_bcd #(.DIGITS(4), .PERIOD_W(16), .RESET_PERIOD(16'd1000), .SYNC_STAGES(2), .MUX_DIV(MUX)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .signal_i(signal), .period_i(period), .period_load_i(period_load),
    .segments_o(seg_a), .digit_en_o(den_a), .overflow_o(ovf_a), .result_valid_o(rv_a), .dbg_state_o(st_a));

  freq_counter_bcd #(.DIGITS(2), .PERIOD_W(16), .RESET_PERIOD(16'd1000), .SYNC_STAGES(2), .MUX_DIV(MUX)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .signal_i(signal), .period_i(period), .period_load_i(period_load),
    .segments_o(seg_b), .digit_en_o(den_b), .overflow_o(ovf_b), .result_valid_o(rv_b), .dbg_state_o(st_b));

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic exp_t model(input int cnt, input int gap);
    exp_t e;
    e.va  = (cnt > 9999) ? 9999 : cnt;
    e.oa  = (cnt > 9999) ? 1 : 0;
    e.vb  = (cnt > 99) ? 99 : cnt;
    e.ob  = (cnt > 99) ? 1 : 0;
    e.gap = gap;
    return e;
  endfunction

  function automatic int seg2dig(input logic [6:0] s);
    case (s)
      7'h3F: return 0;
      7'h06: return 1;
      7'h5B: return 2;
      7'h4F: return 3;
      7'h66: return 4;
      7'h6D: return 5;
      7'h7D: return 6;
      7'h07: return 7;
      7'h7F: return 8;
      7'h6F: return 9;
      default: return 15;
    endcase
  endfunction

  task automatic wait_valid(input int limit, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (rv_a) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_total++;
      $display("FAIL valid_timeout: got no result_valid, expected one within %0d cycles", limit);
    end
  endtask

  task automatic read_display(output int va, output int vb, output int onehot_ok);
    int da[4];
    int db[2];
    for (int i = 0; i < 4; i++) da[i] = 15;
    for (int i = 0; i < 2; i++) db[i] = 15;
    onehot_ok = 1;
    for (int k = 0; k < 4 * MUX; k++) begin
      @(negedge clk);
      if (!$onehot(den_a) || !$onehot(den_b)) onehot_ok = 0;
      for (int i = 0; i < 4; i++) if (den_a[i]) da[i] = seg2dig(seg_a);
      for (int i = 0; i < 2; i++) if (den_b[i]) db[i] = seg2dig(seg_b);
    end
    va = da[0] + 10 * da[1] + 100 * da[2] + 1000 * da[3];
    vb = db[0] + 10 * db[1];
  endtask

  // Called at the negedge where result_valid is seen
  task automatic check_result(input string tag, input int gap);
    exp_t e;
    int va, vb, ok;
    e = sb.pop_front();
    if (e.gap > 0) check({tag, "_gap"}, gap, e.gap);
    check({tag, "_overflow_a"}, ovf_a, e.oa);
    check({tag, "_overflow_b"}, ovf_b, e.ob);
    check({tag, "_valid_b"}, rv_b, 1);
    @(negedge clk);
    check({tag, "_valid_width"}, rv_a, 0);
    read_display(va, vb, ok);
    check({tag, "_result_a"}, va, e.va);
    check({tag, "_result_b"}, vb, e.vb);
    check({tag, "_digit_onehot"}, ok, 1);
  endtask

  task automatic load_period(input int per);
    @(posedge clk); #1;
    period = 16'(per);
    period_load = 1'b1;
    @(posedge clk); #1;
    period_load = 1'b0;
  endtask

  // x = cycles after the CLEAR-cycle edge at which the input rises
  task automatic edge_at(input string tag, input int x, input int exp_next);
    int t0, t1, t2;
    man_sig = 1'b0;
    wait_valid(LIM, t0);
    repeat (x) @(posedge clk);
    #1 man_sig = 1'b1;
    sb.push_back(model(exp_next, 52));
    wait_valid(LIM, t1);
    check_result({tag, "_next"}, t1 - t0);
    sb.push_back(model(0, 52));
    wait_valid(LIM, t2);
    check_result({tag, "_after"}, t2 - t1);
  endtask

  initial begin
    int t0, t1, t2;
    vecs[0] = '{100, 10, 10};
    vecs[1] = '{60, 3, 20};
    vecs[2] = '{1000, 4, 250};
    vecs[3] = '{1000, 0, 0};
    vecs[4] = '{200, 2, 100};
    vecs[5] = '{198, 2, 99};
    vecs[6] = '{0, 0, 0};

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", st_a, 0);
    check("rst_digit_en_a", den_a, 1);
    check("rst_digit_en_b", den_b, 1);
    check("rst_segments", seg_a, 7'h3F);
    check("rst_overflow", ovf_a, 0);
    check("rst_valid", rv_a, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      spacing = vecs[i].spc;
      load_period(vecs[i].per);
      sb.push_back(model(vecs[i].cnt, ((vecs[i].per == 0) ? 1 : vecs[i].per) + 2));
      wait_valid(LIM, t0);
      wait_valid(LIM, t1);
      wait_valid(LIM, t2);
      check_result($sformatf("v%0d", i), t2 - t1);
    end

    // Asynchronous reset part-way through a counting window
    spacing = 10;
    load_period(1000);
    wait_valid(LIM, t0);
    wait_valid(LIM, t0);
    wait_valid(LIM, t0);
    check("pre_reset_overflow_b", ovf_b, 1);
    repeat (370) @(negedge clk);
    #2 reset = 1'b1;
    spacing = 0;
    #1;
    check("async_state", st_a, 0);
    check("async_digit_en", den_a, 1);
    check("async_segments_a", seg_a, 7'h3F);
    check("async_segments_b", seg_b, 7'h3F);
    check("async_overflow_b", ovf_b, 0);
    check("async_valid", rv_a, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    spacing = 10;
    check("walk0_digit_en", den_a, 1);
    for (int k = 1; k <= 5; k++) begin
      repeat (MUX) @(negedge clk);
      check($sformatf("walk%0d_digit_en", k), den_a, 4'b0001 << (k % 4));
      check($sformatf("walk%0d_segments", k), seg_a, 7'h3F);
    end
    sb.push_back(model(100, -1));
    wait_valid(LIM, t0);
    check_result("post_reset", 0);

    // Period change mid-window takes effect only at the next CLEAR
    repeat (300) @(posedge clk);
    load_period(50);
    sb.push_back(model(100, 1002));
    wait_valid(LIM, t1);
    check_result("load_cur", t1 - t0);
    sb.push_back(model(5, 52));
    wait_valid(LIM, t2);
    check_result("load_next", t2 - t1);

    gen_en = 1'b0;
    edge_at("edge_last_count", 48, 1);
    edge_at("edge_latch", 49, 0);
    edge_at("edge_clear", 50, 0);

    load_period(0);
    wait_valid(LIM, t0);
    wait_valid(LIM, t0);
    wait_valid(LIM, t0);
    check("p0_clear", st_a, 0);
    @(negedge clk);
    check("p0_count", st_a, 1);
    @(negedge clk);
    check("p0_latch", st_a, 2);
    @(negedge clk);
    check("p0_valid_again", rv_a, 1);
    check("p0_clear_again", st_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
